// File: rtl/serdes_pkg.sv
// Shared types and constants for the serializer/deserializer pair.
package serdes_pkg;

   typedef enum logic {
      IDLE_S    = 1'b0,
      COLLECT_S = 1'b1
   } state_t;

   localparam int DEF_DATA_BUS_WIDTH = 16;
   localparam int MOD_FULL           = 0;

endpackage

// File: rtl/deserializer.sv
// Rebuilds MSB-first serial bursts into parallel words; strobe 1 cycle after the last bit or the idle cycle ending a burst.
// No backpressure: one bit per valid cycle is accepted unconditionally.
module deserializer
   import serdes_pkg::*;
#(
   parameter int DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH,
   parameter int DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
)(
   input  logic                      clk_i,
   input  logic                      srst_i,
   input  logic                      data_i,
   input  logic                      data_val_i,
   output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
   output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
   output logic                      deser_data_val_o
);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [DATA_BUS_WIDTH-1:0] r_buf;
   logic [DATA_BUS_WIDTH-1:0] w_buf_nxt;
   logic [DATA_MOD_WIDTH-1:0] r_cnt;
   logic [DATA_MOD_WIDTH-1:0] w_cnt_nxt;
   logic                      w_full;
   logic                      w_part;
   logic [DATA_MOD_WIDTH:0]   w_pad;
   logic [DATA_BUS_WIDTH-1:0] r_data;
   logic [DATA_MOD_WIDTH-1:0] r_mod;
   logic                      r_val;

   // Number of zero bits appended below the received bits of a partial word.
   assign w_pad = (DATA_MOD_WIDTH+1)'(DATA_BUS_WIDTH) - {1'b0, r_cnt};

   always_comb begin
      w_state_nxt = r_state;
      w_buf_nxt   = r_buf;
      w_cnt_nxt   = r_cnt;
      w_full      = 1'b0;
      w_part      = 1'b0;
      case (r_state)
         IDLE_S: begin
            if (data_val_i) begin
               w_buf_nxt   = {r_buf[DATA_BUS_WIDTH-2:0], data_i};
               w_cnt_nxt   = DATA_MOD_WIDTH'(1);
               w_state_nxt = COLLECT_S;
            end
         end
         COLLECT_S: begin
            if (data_val_i) begin
               w_buf_nxt = {r_buf[DATA_BUS_WIDTH-2:0], data_i};
               // Counter wraps to 0 on the completing bit.
               w_cnt_nxt = r_cnt + DATA_MOD_WIDTH'(1);
               if (r_cnt == DATA_MOD_WIDTH'(DATA_BUS_WIDTH-1)) begin
                  w_full      = 1'b1;
                  w_state_nxt = IDLE_S;
               end
            end else begin
               w_part      = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE_S;
            end
         end
         default: w_state_nxt = IDLE_S;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_state <= IDLE_S;
         r_buf   <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
         r_mod   <= '0;
         r_val   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_buf   <= w_buf_nxt;
         r_cnt   <= w_cnt_nxt;
         r_val   <= w_full | w_part;
         if (w_full) begin
            r_data <= w_buf_nxt;
            r_mod  <= DATA_MOD_WIDTH'(MOD_FULL);
         end else if (w_part) begin
            r_data <= r_buf << w_pad;
            r_mod  <= r_cnt;
         end
      end
   end

   assign deser_data_o     = r_data;
   assign deser_data_mod_o = r_mod;
   assign deser_data_val_o = r_val;

endmodule
